// File: rtl/reset_debouncer.sv
// Push-button conditioner: synchronizes and debounces a raw button, then
// stretches the debounced level (and the block reset) into a core reset.
module reset_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int STRETCH_CYCLES    = 16,
  parameter bit BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic reset_out,
  output logic button_level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] SC_LOAD  = SW'(STRETCH_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sc_q, sc_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pulse_q, pulse_d;
  logic          sample;

  assign sync1_d = button_in;
  assign sync2_d = sync1_q;
  assign sample  = sync2_q ^ BUTTON_ACTIVE_LOW;

  // Synchronizer flops reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= BUTTON_ACTIVE_LOW;
      sync2_q <= BUTTON_ACTIVE_LOW;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      sc_q    <= SC_LOAD;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sample) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed restores PRESSED silently, without a pulse.
        if (sample) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sc_d = sc_q;
    if (button_level) begin
      sc_d = SC_LOAD;
    end else if (sc_q != '0) begin
      sc_d = sc_q - SW'(1);
    end
  end

  assign button_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_pulse  = pulse_q;
  assign reset_out    = button_level || (sc_q != '0);

endmodule

// File: tb/tb_reset_debouncer.sv
// Directed-vector bench for reset_debouncer: stimulus pushes expected outputs
// per cycle into a scoreboard queue that a separate monitor drains and checks.
module tb_reset_debouncer;

  logic clock = 1'b0;
  logic reset;
  logic btn0, btn1;
  logic ro0, bl0, pp0;
  logic ro1, bl1, pp1;

  always #5 clock = ~clock;

  reset_debouncer #(
    .DEBOUNCE_CYCLES  (4),
    .STRETCH_CYCLES   (3),
    .BUTTON_ACTIVE_LOW(1'b0)
  ) dut0 (
    .clock       (clock),
    .reset       (reset),
    .button_in   (btn0),
    .reset_out   (ro0),
    .button_level(bl0),
    .press_pulse (pp0)
  );

  reset_debouncer #(
    .DEBOUNCE_CYCLES  (4),
    .STRETCH_CYCLES   (3),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .button_in   (btn1),
    .reset_out   (ro1),
    .button_level(bl1),
    .press_pulse (pp1)
  );

  // Expected {reset_out, button_level, press_pulse} after one clock edge.
  typedef struct {
    int         cyc;
    logic [2:0] e0;
    bit         chk1;
    logic [2:0] e1;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc_num      = 0;

  task automatic applyStimulus(input int n, input logic b0, input logic b1,
                               input logic r, input logic [2:0] e0,
                               input bit chk1, input logic [2:0] e1);
    exp_t item;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = r;
      btn0  = b0;
      btn1  = b1;
      cyc_num++;
      item.cyc  = cyc_num;
      item.e0   = e0;
      item.chk1 = chk1;
      item.e1   = e1;
      sb.push_back(item);
    end
  endtask

  task automatic s0(input int n, input logic b0, input logic r, input logic [2:0] e0);
    applyStimulus(n, b0, 1'b1, r, e0, 1'b0, 3'b000);
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("dut0.reset_out",    e.cyc, ro0, e.e0[2]);
        checkOutput("dut0.button_level", e.cyc, bl0, e.e0[1]);
        checkOutput("dut0.press_pulse",  e.cyc, pp0, e.e0[0]);
        if (e.chk1) begin
          checkOutput("dut1.reset_out",    e.cyc, ro1, e.e1[2]);
          checkOutput("dut1.button_level", e.cyc, bl1, e.e1[1]);
          checkOutput("dut1.press_pulse",  e.cyc, pp1, e.e1[0]);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    btn0  = 1'b0;
    btn1  = 1'b1;

    // Reset for two cycles, then three stretched cycles of reset_out.
    applyStimulus(2, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 3'b100);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'b100);
    applyStimulus(3, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);

    // Ten 3-cycle glitch bursts must be rejected completely.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(3, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
      applyStimulus(3, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);
    end
    applyStimulus(4, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);

    // Clean press: level and pulse rise on the 6th edge.
    s0(5, 1'b1, 1'b0, 3'b000);
    s0(1, 1'b1, 1'b0, 3'b111);
    s0(6, 1'b1, 1'b0, 3'b110);

    // Short dip is ignored, then a held release falls on the 4th low sample.
    s0(2, 1'b0, 1'b0, 3'b110);
    s0(2, 1'b1, 1'b0, 3'b110);
    s0(5, 1'b0, 1'b0, 3'b110);
    s0(3, 1'b0, 1'b0, 3'b100);
    s0(3, 1'b0, 1'b0, 3'b000);

    // Reset while pressed, button released during reset.
    s0(5, 1'b1, 1'b0, 3'b000);
    s0(1, 1'b1, 1'b0, 3'b111);
    s0(3, 1'b1, 1'b0, 3'b110);
    s0(2, 1'b0, 1'b1, 3'b100);
    s0(2, 1'b0, 1'b0, 3'b100);
    s0(3, 1'b0, 1'b0, 3'b000);

    // Reset during PRESS_WAIT with the button held: no pulse, full re-debounce.
    s0(4, 1'b1, 1'b0, 3'b000);
    s0(1, 1'b1, 1'b1, 3'b100);
    s0(2, 1'b1, 1'b0, 3'b100);
    s0(3, 1'b1, 1'b0, 3'b000);
    s0(1, 1'b1, 1'b0, 3'b111);
    s0(2, 1'b1, 1'b0, 3'b110);
    s0(5, 1'b0, 1'b0, 3'b110);
    s0(3, 1'b0, 1'b0, 3'b100);
    s0(2, 1'b0, 1'b0, 3'b000);

    // Active-low instance: press by driving low, release by driving high.
    applyStimulus(5, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b111);
    applyStimulus(3, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b110);
    applyStimulus(5, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b110);
    applyStimulus(3, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b100);
    applyStimulus(2, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clock);
      #2;
      guard++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
